// File: rtl/cpu_pkg.sv
// Shared CPU definitions: decoder encodings,
// opcode constants and fetch FSM states.
package cpu_pkg;

  localparam logic [1:0] JUMP_TARGET = 2'b00;
  localparam logic [1:0] JUMP_SEQ    = 2'b01;
  localparam logic [1:0] JUMP_REG    = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  typedef enum logic [1:0] {
    S_RESET,
    S_FETCH,
    S_HOLD,
    S_ERROR
  } fetch_state_t;

  // Word offset of a branch immediate, as a byte offset.
  function automatic logic [31:0] brOffset(
    input logic [15:0] imm
  );
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection from decoder jump/branch
// controls and the ALU zero flag.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [1:0]  jump,
  input  logic        branch,
  input  logic        branch_type,
  input  logic        zero,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc
);

  logic [31:0] pc4;
  logic        taken;
  logic        unusedOpcode;

  assign pc4          = pc + 32'd4;
  assign taken        = branch & (branch_type ? zero : ~zero);
  assign unusedOpcode = ^instr[31:26];

  // Pick the target; jump code 11 falls through as sequential.
  always_comb begin
    next_pc = pc4;
    unique case (1'b1)
      (jump == JUMP_TARGET):
        next_pc = {pc4[31:28], instr[25:0], 2'b00};
      (jump == JUMP_REG):
        next_pc = jr_target;
      default:
        next_pc = taken ? pc4 + brOffset(instr[15:0]) : pc4;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, imem req/ack handshake,
// instruction latch and commit-time PC update.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  input  logic        commit_i,
  input  logic [1:0]  jump_i,
  input  logic        branch_i,
  input  logic        branch_type_i,
  input  logic        zero_i,
  input  logic [31:0] jr_target_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        error_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);

  fetch_state_t state;
  fetch_state_t stateNext;
  logic [31:0]  pcReg;
  logic [31:0]  instrReg;
  logic [31:0]  nextPc;
  logic [CW-1:0] waitCnt;
  logic         timeoutHit;

  next_pc_calc uNextPc (
    .pc          (pcReg),
    .instr       (instrReg),
    .jump        (jump_i),
    .branch      (branch_i),
    .branch_type (branch_type_i),
    .zero        (zero_i),
    .jr_target   (jr_target_i),
    .next_pc     (nextPc)
  );

  assign timeoutHit = (TIMEOUT_CYCLES != 0) &&
                      (waitCnt == CW'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= S_RESET;
    else        state <= stateNext;
  end

  // Next-state logic.
  always_comb begin
    stateNext = state;
    case (state)
      S_RESET: stateNext = S_FETCH;
      S_FETCH: begin
        if (imem_ack_i)      stateNext = S_HOLD;
        else if (timeoutHit) stateNext = S_ERROR;
      end
      S_HOLD: begin
        if (commit_i)
          stateNext = (nextPc[1:0] != 2'b00) ? S_ERROR : S_FETCH;
      end
      S_ERROR: stateNext = S_ERROR;
      default: stateNext = S_ERROR;
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    imem_req_o    = 1'b0;
    instr_valid_o = 1'b0;
    error_o       = 1'b0;
    case (state)
      S_FETCH: imem_req_o    = 1'b1;
      S_HOLD:  instr_valid_o = 1'b1;
      S_ERROR: error_o       = 1'b1;
      default: ;
    endcase
  end

  // PC, instruction latch and fetch wait counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pcReg    <= RESET_PC;
      instrReg <= '0;
      waitCnt  <= '0;
    end else begin
      if (state == S_FETCH) begin
        if (imem_ack_i) instrReg <= imem_data_i;
        else            waitCnt  <= waitCnt + 1'b1;
      end else begin
        waitCnt <= '0;
      end
      if (state == S_HOLD && commit_i) pcReg <= nextPc;
    end
  end

  assign pc_o        = pcReg;
  assign imem_addr_o = pcReg;
  assign instr_o     = instrReg;
  assign pc_plus4_o  = pcReg + 32'd4;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of the main decoder (Control). It holds the PC and fetches one instruction word per instruction through a req/ack handshake to instruction memory. It presents the latched instruction (opcode [31:26], funct [5:0]) to the decoder and datapath. When the datapath commits, it computes the next PC from the decoder's jump/branch outputs and the ALU zero flag.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT_CYCLES, 16, max wait cycles for imem_ack_i per fetch; 0 disables the watchdog

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
imem_req_o  out  1  fetch request
imem_addr_o  out  32  fetch byte address (= pc_o)
imem_ack_i  in  1  memory returns data this cycle
imem_data_i  in  32  instruction word, valid when imem_ack_i=1
instr_o  out  32  latched instruction to decoder/datapath
instr_valid_o  out  1  instr_o is valid and awaiting commit
commit_i  in  1  datapath finished current instruction; next-PC inputs are valid this cycle
jump_i  in  2  decoder Jump: 00=j/jal target, 01=sequential/branch, 10=jr, 11=treated as 01
branch_i  in  1  decoder Branch
branch_type_i  in  1  1=beq (taken on zero), 0=bne (taken on !zero)
zero_i  in  1  ALU zero flag
jr_target_i  in  32  rs register value for jr
pc_o  out  32  PC of current instruction
pc_plus4_o  out  32  pc_o+4 (jal link value)
error_o  out  1  sticky fault: misaligned next PC or fetch timeout

Behaviour:
- Reset (rst_i=0, asynchronous): pc_o=RESET_PC, imem_req_o=0, instr_o=0, instr_valid_o=0, error_o=0, wait counter=0, state=S_RESET. A reset mid-fetch drops imem_req_o immediately. A late ack is ignored.
- States: S_RESET, S_FETCH, S_HOLD, S_ERROR. All outputs are registered (Moore).
- S_RESET: goes unconditionally to S_FETCH on the first clock edge after reset is released.
- S_FETCH:
  - imem_req_o=1, imem_addr_o=pc_o. Address is stable for the whole request.
  - On imem_ack_i=1: instr_o<=imem_data_i, go to S_HOLD. Next cycle imem_req_o=0 and instr_valid_o=1. The ack-to-valid latency is 1 cycle.
  - Each cycle with ack=0 increments the wait counter. If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES, go to S_ERROR. The counter clears on entry to S_FETCH.
- S_HOLD:
  - instr_o, pc_o and instr_valid_o are held.
  - On commit_i=1: pc_o<=next_pc, instr_valid_o<=0, then go to S_FETCH, or to S_ERROR if next_pc[1:0]!=0.
  - commit_i is ignored in every other state. imem_ack_i is ignored outside S_FETCH.
- S_ERROR: imem_req_o=0, instr_valid_o=0, error_o=1, pc_o frozen. Leaves only on reset.
- Next-PC rules (all arithmetic 32-bit, modulo 2^32, so 32'hFFFF_FFFC+4 wraps to 0):
  - pc4 = pc_o+4.
  - taken = branch_i & (branch_type_i ? zero_i : ~zero_i).
  - jump_i=00: next_pc = {pc4[31:28], instr_o[25:0], 2'b00}.
  - jump_i=10: next_pc = jr_target_i.
  - jump_i=01/11: next_pc = taken ? pc4 + ({{14{instr_o[15]}}, instr_o[15:0], 2'b00}) : pc4.
- pc_plus4_o is combinational pc_o+4.

Decomposition:
- Shared package cpu_pkg holds:
  - jump encodings JUMP_TARGET=2'b00, JUMP_SEQ=2'b01, JUMP_REG=2'b10;
  - opcode constants (OP_RTYPE=6'h00, OP_BEQ=6'h04, OP_BNE=6'h05, OP_J=6'h02, OP_JAL=6'h03) and FUNCT_JR=6'h08;
  - fetch state enum.
- One combinational sub-module, next_pc_calc (inputs pc, instr, jump, branch, branch_type, zero, jr_target; output next_pc), instantiated once.

Test Plan:
- Reset with RESET_PC=0x0, ack=1 two cycles after req -> imem_addr_o=0x0. instr_valid_o rises 1 cycle after ack with instr_o=imem_data_i. Reset values are checked before release.
- Sequential plus wrap: pc=0xFFFF_FFFC, jump_i=01, branch_i=0, commit -> next fetch addr=0x0000_0000.
- Branches at pc=0x100, instr[15:0]=0xFFFE:
  - beq (branch_type_i=1), zero_i=1 -> next PC 0x0FC;
  - beq, zero_i=0 -> 0x104;
  - bne (branch_type_i=0), zero_i=0 -> 0x0FC.
- Jumps at pc=0x4000_0010:
  - j with instr[25:0]=0x000_0040 -> next PC 0x4000_0100;
  - jr with jr_target_i=0x0000_0200 -> 0x200;
  - jr with 0x0000_0202 -> error_o=1, imem_req_o stays 0 until reset.
- Timeout with TIMEOUT_CYCLES=16 and ack held low -> S_ERROR after 16 wait cycles. The same with ack on the 15th wait cycle -> normal fetch.
- Protocol hygiene:
  - commit_i pulsed during S_FETCH -> no PC change;
  - ack during S_HOLD -> instr_o unchanged;
  - rst_i asserted mid-fetch -> imem_req_o=0 asynchronously.
